accum_stream_arbiter: RTL and testbench
=======================================

Name: accum_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-stream accumulator (INPUT_WIDTH=16, OUTPUT_WIDTH=32, packet delimited by tlast) among NUM_INPUTS requesting streams.
- Grants a whole packet at a time, so each accumulated result never mixes data from two requesters.
- Tags each forwarded beat with the source index on out_tid; downstream logic uses it to route the result back to its requester.

Parameters:
- NUM_INPUTS, 4, number of requesting streams; must be >= 1, else $fatal at elaboration.
- DATA_WIDTH, 16, tdata width of every input and of the output; must be a multiple of 8, else $fatal.
- ID_WIDTH (localparam), max(1, $clog2(NUM_INPUTS)), width of out_tid.

Ports:
- aclk  input  1  clock
- arst_n  input  1  reset, synchronous, active-low; clock aclk
- in_tvalid  input  NUM_INPUTS  per-requester tvalid; bit i = requester i
- in_tready  output  NUM_INPUTS  per-requester tready
- in_tdata  input  NUM_INPUTS*DATA_WIDTH  flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_tlast  input  NUM_INPUTS  per-requester tlast
- out_tvalid  output  1  to accumulator in_tvalid
- out_tready  input  1  from accumulator in_tready
- out_tdata  output  DATA_WIDTH  to accumulator in_tdata
- out_tlast  output  1  to accumulator in_tlast
- out_tid  output  ID_WIDTH  index of the granted requester
- busy  output  1  high while in LOCKED

Behaviour:
- Registered state: state (IDLE/LOCKED), grant_r (ID_WIDTH), last_r (ID_WIDTH).
- Reset: state=IDLE, grant_r=0, last_r=NUM_INPUTS-1, so requester 0 has first priority. While arst_n=0 and in IDLE:
  - out_tvalid=0, out_tdata=0, out_tlast=0, out_tid=0
  - all in_tready=0, busy=0
- IDLE:
  - All in_tready=0; outputs held at their reset values.
  - If any in_tvalid is high, search indices last_r+1, last_r+2, ... modulo NUM_INPUTS. Load the first valid index into grant_r and go to LOCKED on the next edge.
  - If no request, stay in IDLE.
- LOCKED (busy=1), with g = grant_r:
  - out_tvalid=in_tvalid[g], out_tdata=in_tdata[g], out_tlast=in_tlast[g], out_tid=g (combinational mux).
  - in_tready[g]=out_tready; all other in_tready=0.
  - out_tvalid never depends on out_tready.
  - Beat accepted when out_tvalid && out_tready. If the accepted beat has out_tlast=1: last_r<=g, state<=IDLE on that edge. Otherwise stay LOCKED.
- Latency:
  - Request to first output beat: exactly 1 cycle (the IDLE arbitration cycle). No data latency in LOCKED.
  - Exactly one bubble cycle between consecutive packets, even from the same requester.
- Boundary conditions:
  - Granted requester drops tvalid between beats: stay LOCKED and wait indefinitely; other requesters stay blocked.
  - Single-beat packet (tlast on first beat): accepted, return to IDLE next cycle.
  - Backpressure (out_tready=0 while out_tvalid=1): hold state; in_tready[g]=0.
  - Non-granted requesters never see in_tready=1, regardless of their tvalid.
  - All requesters continuously valid: grant sequence 0,1,2,...,N-1,0,...
  - Only the last-granted requester valid: it is re-granted (round-robin wraps to itself).
  - NUM_INPUTS=1: grant always 0, out_tid=0; IDLE/LOCKED sequencing unchanged.
  - Reset asserted mid-packet: next edge forces IDLE and all reset values; the partial packet is abandoned.
- No combinational path from in_tvalid to in_tready of any requester.

Test Plan:
- Reset, then requester 2 sends 3 beats (5,6,7; tlast on 7), others idle -> out_tvalid high from cycle 2; out_tdata 5,6,7; out_tid=2; out_tlast only on 7; busy drops the cycle after; downstream accumulator outputs 18.
- All 4 requesters continuously send 2-beat packets with data (10*i+1, 10*i+2) -> grant order 0,1,2,3,0,1; out_tid matches; exactly one out_tvalid=0 cycle between packets; accumulator results 3,23,43,63,3,23.
- Requester 1 sends a 4-beat packet while out_tready toggles 1,0,0,1,1,0,1 -> beats delivered in order with no loss or duplication; in_tready[1] mirrors out_tready; in_tready[0,2,3]=0 throughout.
- Requester 3 locked; tvalid low for 5 cycles mid-packet while requester 0 is valid -> no grant change and in_tready[0]=0 until requester 3's tlast is accepted; requester 0 is then granted.
- Requester 0 single-beat packets (tlast=1) back-to-back with no competitors -> one accepted beat every 2 cycles; out_tid=0 each time.
- arst_n pulsed low for 1 cycle during beat 2 of a 4-beat packet from requester 1 -> next cycle busy=0, out_tvalid=0, all in_tready=0; after release, requester 0 (if valid) is granted first.

Source files
------------

// File: rtl/accum_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-stream accumulator among
// NUM_INPUTS requesters; each granted packet is forwarded whole and tagged with its source index.
module accum_stream_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                                   aclk,
    input  logic                                   arst_n,
    input  logic [NUM_INPUTS-1:0]                  in_tvalid,
    output logic [NUM_INPUTS-1:0]                  in_tready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]       in_tdata,
    input  logic [NUM_INPUTS-1:0]                  in_tlast,
    output logic                                   out_tvalid,
    input  logic                                   out_tready,
    output logic [DATA_WIDTH-1:0]                  out_tdata,
    output logic                                   out_tlast,
    output logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] out_tid,
    output logic                                   busy
);

    localparam int unsigned ID_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int          N_I      = int'(NUM_INPUTS);

    generate
        if (NUM_INPUTS == 0) begin : g_bad_num_inputs
            $fatal(1, "accum_stream_arbiter: NUM_INPUTS must be >= 1");
        end
        if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
            $fatal(1, "accum_stream_arbiter: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   w_grant_nxt;
    logic [ID_WIDTH-1:0]   r_last;
    logic [ID_WIDTH-1:0]   w_last_nxt;

    logic [ID_WIDTH-1:0]   w_rr_pick;
    int                    w_rr_dist;
    int                    w_cand_dist;
    logic                  w_req_any;

    logic                  w_sel_valid;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;
    logic                  w_accept;

    assign w_req_any = |in_tvalid;

    // Round-robin pick: valid requester with the smallest distance past the last winner.
    always_comb begin
        w_rr_pick   = '0;
        w_rr_dist   = N_I;
        w_cand_dist = 0;
        for (int i = 0; i < N_I; i++) begin
            w_cand_dist = (i + 2 * N_I - int'(r_last) - 1) % N_I;
            if (in_tvalid[i] && (w_cand_dist < w_rr_dist)) begin
                w_rr_dist = w_cand_dist;
                w_rr_pick = ID_WIDTH'(i);
            end
        end
    end

    // Mux the granted requester's beat onto the shared path.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N_I; i++) begin
            if (r_grant == ID_WIDTH'(i)) begin
                w_sel_valid = in_tvalid[i];
                w_sel_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last  = in_tlast[i];
            end
        end
    end

    assign w_accept = out_tvalid && out_tready;

    // State register; reset leaves requester 0 with first priority.
    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= ID_WIDTH'(NUM_INPUTS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state: arbitrate in IDLE, release the lock on an accepted tlast beat.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        if (r_state == ST_IDLE) begin
            if (w_req_any) begin
                w_state_nxt = ST_LOCKED;
                w_grant_nxt = w_rr_pick;
            end
        end else begin
            if (w_accept && w_sel_last) begin
                w_state_nxt = ST_IDLE;
                w_last_nxt  = r_grant;
            end
        end
    end

    // Outputs: only the granted requester sees tready, and only while locked.
    always_comb begin
        out_tvalid = 1'b0;
        out_tdata  = '0;
        out_tlast  = 1'b0;
        out_tid    = '0;
        in_tready  = '0;
        busy       = 1'b0;
        if (r_state == ST_LOCKED) begin
            busy       = 1'b1;
            out_tvalid = w_sel_valid;
            out_tdata  = w_sel_data;
            out_tlast  = w_sel_last;
            out_tid    = r_grant;
            for (int i = 0; i < N_I; i++) begin
                if (r_grant == ID_WIDTH'(i)) begin
                    in_tready[i] = out_tready;
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_stream_arbiter.sv
// Bench for accum_stream_arbiter: queue-driven requesters, packet-level round-robin
// reference model feeding a scoreboard, and a monitor checking beats and handshake rules.
module tb_accum_stream_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int IDW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    gap;
    } beat_t;

    typedef struct packed {
        logic [IDW-1:0] tid;
        logic [DW-1:0]  data;
        logic           last;
    } exp_t;

    logic              aclk;
    logic              arst_n;
    logic [N-1:0]      in_tvalid;
    logic [N-1:0]      in_tready;
    logic [N*DW-1:0]   in_tdata;
    logic [N-1:0]      in_tlast;
    logic              out_tvalid;
    logic              out_tready;
    logic [DW-1:0]     out_tdata;
    logic              out_tlast;
    logic [IDW-1:0]    out_tid;
    logic              busy;

    accum_stream_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .aclk       (aclk),
        .arst_n     (arst_n),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tdata   (in_tdata),
        .in_tlast   (in_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .out_tid    (out_tid),
        .busy       (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    beat_t         req_q [N][$];
    logic [DW-1:0] m_dat [N][$];
    int            m_len [N][$];
    int            m_cur [N];
    int            m_last;
    exp_t          sb_q [$];
    int            sum_q [$];
    bit            rdy_q [$];
    bit            rdy_rand;
    bit            fire [N];
    int            gap_cnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_beat(input int i, input logic [DW-1:0] d, input bit last, input int gap,
                            input bit to_drv, input bit to_mdl);
        beat_t b;
        b.data = d;
        b.last = last;
        b.gap  = 4'(gap);
        if (to_drv) req_q[i].push_back(b);
        if (to_mdl) begin
            m_dat[i].push_back(d);
            m_cur[i]++;
            if (last) begin
                m_len[i].push_back(m_cur[i]);
                m_cur[i] = 0;
            end
        end
    endtask

    // Packet-level round robin over requesters holding pending packets.
    task automatic model_commit();
        int i;
        int len;
        int sum;
        logic [DW-1:0] d;
        exp_t e;
        forever begin
            i = -1;
            for (int k = 1; k <= N; k++) begin
                if (i < 0 && m_len[(m_last + k) % N].size() != 0) i = (m_last + k) % N;
            end
            if (i < 0) break;
            len = m_len[i].pop_front();
            sum = 0;
            for (int b = 0; b < len; b++) begin
                d = m_dat[i].pop_front();
                e.tid  = IDW'(i);
                e.data = d;
                e.last = (b == len - 1);
                sb_q.push_back(e);
                sum += int'(d);
            end
            sum_q.push_back(sum);
            m_last = i;
        end
    endtask

    task automatic step();
        @(negedge aclk);
        #3;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        bit pend;
        n = 0;
        forever begin
            pend = (sb_q.size() != 0);
            for (int i = 0; i < N; i++) if (req_q[i].size() != 0) pend = 1'b1;
            if (!pend || n >= budget) break;
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s drain timeout actual=%0d pending expected=0", name, sb_q.size());
            sb_q.delete();
            sum_q.delete();
            for (int i = 0; i < N; i++) req_q[i].delete();
        end
        repeat (3) step();
    endtask

    // Requester drivers plus downstream tready; inputs change only on the falling edge.
    initial begin : drv
        in_tvalid  = '0;
        in_tdata   = '0;
        in_tlast   = '0;
        out_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            fire[i]    = 1'b0;
            gap_cnt[i] = -1;
        end
        forever begin
            @(negedge aclk);
            for (int i = 0; i < N; i++) begin
                if (fire[i] && req_q[i].size() != 0) begin
                    void'(req_q[i].pop_front());
                    gap_cnt[i] = -1;
                end
                in_tvalid[i]          = 1'b0;
                in_tdata[i*DW +: DW]  = '0;
                in_tlast[i]           = 1'b0;
                if (req_q[i].size() == 0) begin
                    gap_cnt[i] = -1;
                end else begin
                    if (gap_cnt[i] < 0) gap_cnt[i] = int'(req_q[i][0].gap);
                    if (gap_cnt[i] > 0) begin
                        gap_cnt[i]--;
                    end else begin
                        in_tvalid[i]         = 1'b1;
                        in_tdata[i*DW +: DW] = req_q[i][0].data;
                        in_tlast[i]          = req_q[i][0].last;
                    end
                end
            end
            if (rdy_q.size() != 0) out_tready = rdy_q.pop_front();
            else if (rdy_rand)     out_tready = ($urandom_range(3) != 0);
            else                   out_tready = 1'b1;
            #1;
            for (int i = 0; i < N; i++) fire[i] = in_tvalid[i] && in_tready[i];
        end
    end

    // Monitor: scoreboard on accepted beats, accumulator sums, handshake and bubble rules.
    initial begin : mon
        bit after_last;
        bit idle_req;
        int acc;
        exp_t e;
        logic [N-1:0] exp_rdy;
        after_last = 1'b0;
        idle_req   = 1'b0;
        acc        = 0;
        forever begin
            @(negedge aclk);
            #2;
            if (arst_n !== 1'b1) begin
                after_last = 1'b0;
                idle_req   = 1'b0;
                acc        = 0;
                continue;
            end
            exp_rdy = '0;
            if (busy && out_tready) exp_rdy[out_tid] = 1'b1;
            chk("in_tready_rule", 64'(in_tready), 64'(exp_rdy));
            if (after_last) chk("bubble_after_tlast", {62'd0, busy, out_tvalid}, 64'd0);
            if (idle_req)   chk("grant_latency", {62'd0, busy, out_tvalid}, 64'd3);
            if (out_tvalid && out_tready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", out_tdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_tid", 64'(out_tid), 64'(e.tid));
                    chk("beat_data", 64'(out_tdata), 64'(e.data));
                    chk("beat_last", 64'(out_tlast), 64'(e.last));
                end
                acc += int'(out_tdata);
                if (out_tlast) begin
                    if (sum_q.size() != 0) chk("accum_sum", 64'(acc), 64'(sum_q.pop_front()));
                    acc = 0;
                end
            end
            after_last = out_tvalid && out_tready && out_tlast;
            idle_req   = !busy && (in_tvalid != '0);
        end
    end

    initial begin : main
        int n;
        rdy_rand = 1'b0;
        arst_n   = 1'b0;
        m_last   = N - 1;
        for (int i = 0; i < N; i++) m_cur[i] = 0;
        repeat (3) step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("reset_out_tdata", 64'(out_tdata), 64'd0);
        chk("reset_out_tid", 64'(out_tid), 64'd0);
        chk("reset_in_tready", 64'(in_tready), 64'd0);
        arst_n = 1'b1;
        step();

        // Every requester has 2-beat packets (10*i+1, 10*i+2); order 0,1,2,3,0,1.
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < ((i < 2) ? 2 : 1); p++) begin
                add_beat(i, DW'(10 * i + 1), 1'b0, 0, 1'b1, 1'b1);
                add_beat(i, DW'(10 * i + 2), 1'b1, 0, 1'b1, 1'b1);
            end
        end
        model_commit();
        drain("all_requesters", 200);

        // Requester 2 alone: 5,6,7.
        add_beat(2, 16'd5, 1'b0, 0, 1'b1, 1'b1);
        add_beat(2, 16'd6, 1'b0, 0, 1'b1, 1'b1);
        add_beat(2, 16'd7, 1'b1, 0, 1'b1, 1'b1);
        model_commit();
        drain("req2_three_beats", 100);

        // Requester 3 stalls 5 cycles mid-packet while requester 0 waits.
        add_beat(3, 16'd40, 1'b0, 0, 1'b1, 1'b1);
        add_beat(3, 16'd41, 1'b0, 5, 1'b1, 1'b1);
        add_beat(3, 16'd42, 1'b1, 0, 1'b1, 1'b1);
        add_beat(0, 16'd50, 1'b1, 0, 1'b1, 1'b1);
        model_commit();
        drain("gap_hold", 100);

        // Requester 1 under a fixed backpressure pattern.
        for (int b = 0; b < 4; b++) add_beat(1, DW'(60 + b), (b == 3), 0, 1'b1, 1'b1);
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        model_commit();
        drain("backpressure", 100);

        // Requester 0 back-to-back single-beat packets.
        for (int b = 0; b < 4; b++) add_beat(0, DW'(70 + b), 1'b1, 0, 1'b1, 1'b1);
        model_commit();
        drain("single_beat", 100);

        // Reset pulse during beat 2 of a 4-beat packet from requester 1.
        for (int b = 0; b < 4; b++) add_beat(1, DW'(100 + b), (b == 3), 0, 1'b1, 1'b0);
        begin
            exp_t e;
            e.tid  = IDW'(1);
            e.data = 16'd100;
            e.last = 1'b0;
            sb_q.push_back(e);
        end
        n = 0;
        while (!(busy && out_tvalid && out_tready) && n < 50) begin
            step();
            n++;
        end
        chk("reset_pkt_started", 64'(n < 50), 64'd1);
        rdy_q.push_back(1'b0);
        step();
        arst_n = 1'b0;
        add_beat(0, 16'd200, 1'b0, 0, 1'b1, 1'b0);
        add_beat(0, 16'd201, 1'b1, 0, 1'b1, 1'b0);
        step();
        chk("midpkt_reset_busy", 64'(busy), 64'd0);
        chk("midpkt_reset_out_tvalid", 64'(out_tvalid), 64'd0);
        chk("midpkt_reset_in_tready", 64'(in_tready), 64'd0);
        arst_n = 1'b1;
        m_last = N - 1;
        add_beat(0, 16'd200, 1'b0, 0, 1'b0, 1'b1);
        add_beat(0, 16'd201, 1'b1, 0, 1'b0, 1'b1);
        for (int b = 1; b < 4; b++) add_beat(1, DW'(100 + b), (b == 3), 0, 1'b0, 1'b1);
        model_commit();
        drain("after_reset", 100);

        // Randomized rounds with random backpressure and mid-packet gaps.
        rdy_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                int npk;
                npk = int'($urandom_range(3));
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) begin
                        add_beat(i, DW'($urandom), (b == len - 1),
                                 (b == 0) ? 0 : int'($urandom_range(2)), 1'b1, 1'b1);
                    end
                end
            end
            model_commit();
            drain("random_round", 2000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
